// File: rtl/pdm_mic_capture_ctrl.sv
// PDM microphone sequencer and ones-count decimator with valid/ready output.
// Define MIC_STEREO_EN for dual-mic capture on a shared DATA line.
module pdm_mic_capture_ctrl #(
    parameter int CLK_HALF_DIV = 21,
    parameter int DECIM        = 64,
    parameter int WAKE_CYCLES  = 1000000,
    parameter int SW           = $clog2(DECIM) + 1
) (
    input  logic          Clock_100MHz,
    input  logic          Reset_n,
    input  logic          Enable,
    input  logic          Chan_sel,
    input  logic          DATA,
    output logic          CLK,
    output logic          L_R_SEL,
    output logic [SW-1:0] Sample,
    output logic          Sample_valid,
    input  logic          Sample_ready,
    output logic          Sample_chan,
    output logic          Overrun,
    output logic [1:0]    State
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAKE    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_STOP    = 2'd3;

    localparam int DW = (CLK_HALF_DIV > 1) ? $clog2(CLK_HALF_DIV) : 1;
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam int BW = $clog2(DECIM);

    localparam logic [DW-1:0] DIV_TC  = DW'(CLK_HALF_DIV - 1);
    localparam logic [WW-1:0] WAKE_TC = WW'(WAKE_CYCLES - 1);
    localparam logic [BW-1:0] BIT_TC  = BW'(DECIM - 1);

    logic [1:0]    state;
    logic [DW-1:0] div_cnt;
    logic [WW-1:0] wake_cnt;
    logic          div_tc;
    logic          start;
    logic          stop_done;
    logic          cap_hi;
    logic          cap_lo;
    logic          cmp;
    logic [SW-1:0] cmp_val;
    logic          cmp_chan;

    assign State     = state;
    assign div_tc    = (div_cnt == DIV_TC);
    assign start     = (state == ST_IDLE) && Enable;
    assign stop_done = (state == ST_STOP) && div_tc && !CLK;
    assign cap_hi    = (state == ST_CAPTURE) && Enable && div_tc && CLK;
    assign cap_lo    = (state == ST_CAPTURE) && Enable && div_tc && !CLK;

    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            wake_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Enable) begin
                        state    <= ST_WAKE;
                        wake_cnt <= '0;
                    end
                end
                ST_WAKE: begin
                    wake_cnt <= wake_cnt + 1'b1;
                    if (!Enable)
                        state <= ST_STOP;
                    else if (wake_cnt == WAKE_TC)
                        state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (!Enable)
                        state <= ST_STOP;
                end
                default: begin
                    if (stop_done)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    // STOP exits at a low-phase terminal count so CLK never glitches high
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
            CLK     <= 1'b0;
        end else if (state == ST_IDLE || stop_done) begin
            div_cnt <= '0;
            CLK     <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            CLK     <= ~CLK;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifdef MIC_STEREO_EN
    logic [SW-1:0] acc_r;
    logic [SW-1:0] acc_l;
    logic [BW-1:0] cnt_r;
    logic [BW-1:0] cnt_l;
    logic          l_arm;
    logic          cmp_r;
    logic          cmp_l;
    logic          unused_chan_sel;

    assign unused_chan_sel = Chan_sel;
    assign L_R_SEL  = 1'b0;
    assign cmp_r    = cap_hi && (cnt_r == BIT_TC);
    assign cmp_l    = cap_lo && l_arm && (cnt_l == BIT_TC);
    assign cmp      = cmp_r || cmp_l;
    assign cmp_val  = cmp_r ? acc_r + SW'(DATA) : acc_l + SW'(DATA);
    assign cmp_chan = cmp_l;

    // left only starts after the first right bit so right always leads
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_r <= '0;
            acc_l <= '0;
            cnt_r <= '0;
            cnt_l <= '0;
            l_arm <= 1'b0;
        end else if (state != ST_CAPTURE) begin
            acc_r <= '0;
            acc_l <= '0;
            cnt_r <= '0;
            cnt_l <= '0;
            l_arm <= 1'b0;
        end else begin
            if (cap_hi) begin
                l_arm <= 1'b1;
                cnt_r <= cmp_r ? '0 : cnt_r + 1'b1;
                acc_r <= cmp_r ? '0 : acc_r + SW'(DATA);
            end
            if (cap_lo && l_arm) begin
                cnt_l <= cmp_l ? '0 : cnt_l + 1'b1;
                acc_l <= cmp_l ? '0 : acc_l + SW'(DATA);
            end
        end
    end
`else
    logic [SW-1:0] acc;
    logic [BW-1:0] bcnt;
    logic          cap;

    assign cap      = L_R_SEL ? cap_lo : cap_hi;
    assign cmp      = cap && (bcnt == BIT_TC);
    assign cmp_val  = acc + SW'(DATA);
    assign cmp_chan = L_R_SEL;

    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            L_R_SEL <= 1'b0;
        end else if (start) begin
            L_R_SEL <= Chan_sel;
        end
    end

    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            acc  <= '0;
            bcnt <= '0;
        end else if (state != ST_CAPTURE) begin
            acc  <= '0;
            bcnt <= '0;
        end else if (cap) begin
            bcnt <= cmp ? '0 : bcnt + 1'b1;
            acc  <= cmp ? '0 : acc + SW'(DATA);
        end
    end
`endif

    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            Sample       <= '0;
            Sample_valid <= 1'b0;
            Sample_chan  <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            if (start)
                Overrun <= 1'b0;
            if (cmp) begin
                if (!Sample_valid || Sample_ready) begin
                    Sample       <= cmp_val;
                    Sample_chan  <= cmp_chan;
                    Sample_valid <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (Sample_valid && Sample_ready) begin
                Sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_capture_ctrl.sv
// Directed bench for pdm_mic_capture_ctrl (WAKE_CYCLES=100).
// Mono scenarios by default; stereo scenario when MIC_STEREO_EN is defined.
module tb_pdm_mic_capture_ctrl;

    localparam int SW = 7;

    logic          clk;
    logic          Reset_n;
    logic          Enable;
    logic          Chan_sel;
    logic          DATA;
    logic          CLK;
    logic          L_R_SEL;
    logic [SW-1:0] Sample;
    logic          Sample_valid;
    logic          Sample_ready;
    logic          Sample_chan;
    logic          Overrun;
    logic [1:0]    State;

    int     checks = 0;
    int     errors = 0;
    int     mode = 0;
    longint cyc = 0;

    pdm_mic_capture_ctrl #(
        .CLK_HALF_DIV(21),
        .DECIM(64),
        .WAKE_CYCLES(100)
    ) dut (
        .Clock_100MHz(clk),
        .Reset_n(Reset_n),
        .Enable(Enable),
        .Chan_sel(Chan_sel),
        .DATA(DATA),
        .CLK(CLK),
        .L_R_SEL(L_R_SEL),
        .Sample(Sample),
        .Sample_valid(Sample_valid),
        .Sample_ready(Sample_ready),
        .Sample_chan(Sample_chan),
        .Overrun(Overrun),
        .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // mic model: 0 zeros, 1 ones, 2 alternate per bit, 3 follow CLK level
    initial begin
        logic prev;
        logic ph;
        DATA = 1'b0;
        prev = 1'b0;
        ph   = 1'b0;
        forever begin
            @(negedge clk);
            case (mode)
                0: DATA = 1'b0;
                1: DATA = 1'b1;
                2: begin
                    if (prev && !CLK)
                        ph = ~ph;
                    DATA = ph;
                end
                default: DATA = CLK;
            endcase
            prev = CLK;
        end
    end

    task automatic wait_xfer(input int limit, output logic ok,
                             output logic [SW-1:0] v, output logic c,
                             output longint t);
        int n;
        ok = 1'b0;
        v  = '0;
        c  = 1'b0;
        t  = 0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (Sample_valid && Sample_ready) begin
                ok = 1'b1;
                v  = Sample;
                c  = Sample_chan;
                t  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        Reset_n      = 1'b0;
        Enable       = 1'b0;
        Chan_sel     = 1'b0;
        Sample_ready = 1'b0;
        mode         = 0;
        repeat (3) @(negedge clk);
        checks++; if (State !== 2'd0) begin errors++;
            $display("FAIL reset_state got %0d want 0", State); end
        checks++; if (CLK !== 1'b0) begin errors++;
            $display("FAIL reset_clk got %b want 0", CLK); end
        checks++; if (Sample_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", Sample_valid); end
        checks++; if (Sample !== 7'd0) begin errors++;
            $display("FAIL reset_sample got %0d want 0", Sample); end
        checks++; if (Overrun !== 1'b0) begin errors++;
            $display("FAIL reset_overrun got %b want 0", Overrun); end
        checks++; if (L_R_SEL !== 1'b0 || Sample_chan !== 1'b0) begin errors++;
            $display("FAIL reset_lr got %b/%b want 0/0", L_R_SEL, Sample_chan); end
        Reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (CLK !== 1'b0 || Sample_valid !== 1'b0 || State !== 2'd0)
                bad++;
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL idle_hold got %0d bad cycles want 0", bad); end
    endtask

    task automatic count_wake(input string nm);
        int wake;
        int vbad;
        wake = 0;
        vbad = 0;
        while (State == 2'd1 && wake < 300) begin
            wake++;
            if (Sample_valid) vbad++;
            @(negedge clk);
        end
        checks++; if (wake != 100) begin errors++;
            $display("FAIL %s_len got %0d want 100", nm, wake); end
        checks++; if (vbad != 0) begin errors++;
            $display("FAIL %s_valid got %0d want 0", nm, vbad); end
        checks++; if (State !== 2'd2) begin errors++;
            $display("FAIL %s_exit got %0d want 2", nm, State); end
    endtask

    task automatic test_wake_and_ones();
        logic ok;
        logic [SW-1:0] v;
        logic c;
        longint t1;
        longint t2;
        Enable       = 1'b1;
        Chan_sel     = 1'b0;
        Sample_ready = 1'b1;
        mode         = 1;
        @(negedge clk);
        count_wake("wake");
        checks++; if (L_R_SEL !== 1'b0) begin errors++;
            $display("FAIL lr_sel got %b want 0", L_R_SEL); end
        wait_xfer(6000, ok, v, c, t1);
        checks++; if (!ok || v !== 7'd64 || c !== 1'b0) begin errors++;
            $display("FAIL ones_first got ok=%b %0d ch%b want 64 ch0", ok, v, c); end
        wait_xfer(6000, ok, v, c, t2);
        checks++; if (!ok || v !== 7'd64) begin errors++;
            $display("FAIL ones_second got ok=%b %0d want 64", ok, v); end
        checks++; if (t2 - t1 != 2688) begin errors++;
            $display("FAIL period got %0d want 2688", t2 - t1); end
    endtask

    task automatic test_patterns();
        logic ok;
        logic [SW-1:0] v;
        logic c;
        longint t;
        mode = 2;
        wait_xfer(6000, ok, v, c, t);
        for (int i = 0; i < 2; i++) begin
            wait_xfer(6000, ok, v, c, t);
            checks++; if (!ok || v !== 7'd32) begin errors++;
                $display("FAIL alt_%0d got ok=%b %0d want 32", i, ok, v); end
        end
        mode = 0;
        wait_xfer(6000, ok, v, c, t);
        for (int i = 0; i < 2; i++) begin
            wait_xfer(6000, ok, v, c, t);
            checks++; if (!ok || v !== 7'd0) begin errors++;
                $display("FAIL zero_%0d got ok=%b %0d want 0", i, ok, v); end
        end
    endtask

    task automatic test_overrun();
        logic ok;
        logic [SW-1:0] v;
        logic [SW-1:0] held;
        logic c;
        logic seen;
        longint t;
        int unstable;
        int xf;
        mode = 1;
        wait_xfer(6000, ok, v, c, t);
        wait_xfer(6000, ok, v, c, t);
        @(negedge clk);
        Sample_ready = 1'b0;
        seen = 1'b0;
        held = '0;
        unstable = 0;
        for (int i = 0; i < 3 * 2688; i++) begin
            @(negedge clk);
            if (seen && (Sample !== held || Sample_valid !== 1'b1))
                unstable++;
            if (!seen && Sample_valid) begin
                seen = 1'b1;
                held = Sample;
            end
        end
        checks++; if (unstable != 0) begin errors++;
            $display("FAIL hold_stable got %0d changes want 0", unstable); end
        checks++; if (Sample_valid !== 1'b1 || Sample !== 7'd64) begin errors++;
            $display("FAIL hold_value got v=%b %0d want 1 64", Sample_valid, Sample); end
        checks++; if (Overrun !== 1'b1) begin errors++;
            $display("FAIL overrun_set got %b want 1", Overrun); end
        Sample_ready = 1'b1;
        xf = 0;
        for (int i = 0; i < 1000; i++) begin
            if (Sample_valid && Sample_ready) xf++;
            @(negedge clk);
        end
        checks++; if (xf != 1) begin errors++;
            $display("FAIL drain_count got %0d want 1", xf); end
        checks++; if (Overrun !== 1'b1) begin errors++;
            $display("FAIL overrun_sticky got %b want 1", Overrun); end
    endtask

    task automatic test_stop_restart();
        logic ok;
        logic [SW-1:0] v;
        logic c;
        longint t;
        int n;
        int bad;
        Enable = 1'b0;
        @(negedge clk);
        checks++; if (State !== 2'd3) begin errors++;
            $display("FAIL stop_enter got %0d want 3", State); end
        n = 0;
        while (State == 2'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (State !== 2'd0 || CLK !== 1'b0 || n > 43) begin errors++;
            $display("FAIL stop_exit got st%0d clk%b in %0d want st0 clk0", State, CLK, n); end
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (Sample_valid !== 1'b0 || CLK !== 1'b0 || State !== 2'd0)
                bad++;
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL stop_idle got %0d bad cycles want 0", bad); end
        checks++; if (Overrun !== 1'b1) begin errors++;
            $display("FAIL overrun_idle got %b want 1", Overrun); end
        Enable   = 1'b1;
        Chan_sel = 1'b1;
        mode     = 0;
        @(negedge clk);
        checks++; if (Overrun !== 1'b0 || L_R_SEL !== 1'b1) begin errors++;
            $display("FAIL restart got ovr%b lr%b want 0 1", Overrun, L_R_SEL); end
        count_wake("rewake");
        wait_xfer(6000, ok, v, c, t);
        checks++; if (!ok || v !== 7'd0 || c !== 1'b1) begin errors++;
            $display("FAIL restart_sample got ok=%b %0d ch%b want 0 ch1", ok, v, c); end
    endtask

    task automatic test_stereo();
        logic ok;
        logic [SW-1:0] v;
        logic c;
        longint t;
        longint tp;
        Enable       = 1'b1;
        Chan_sel     = 1'b1;
        Sample_ready = 1'b1;
        mode         = 3;
        @(negedge clk);
        count_wake("st_wake");
        checks++; if (L_R_SEL !== 1'b0) begin errors++;
            $display("FAIL st_lr got %b want 0", L_R_SEL); end
        tp = 0;
        for (int i = 0; i < 4; i++) begin
            wait_xfer(6000, ok, v, c, t);
            checks++; if (!ok || c !== i[0] || v !== (i[0] ? 7'd0 : 7'd64)) begin
                errors++;
                $display("FAIL st_%0d got ok=%b %0d ch%b want %0d ch%0d",
                         i, ok, v, c, i[0] ? 0 : 64, i[0]);
            end
            if (i == 1) begin
                checks++; if (t - tp != 21) begin errors++;
                    $display("FAIL st_gap got %0d want 21", t - tp); end
            end
            tp = t;
        end
        checks++; if (Overrun !== 1'b0) begin errors++;
            $display("FAIL st_overrun got %b want 0", Overrun); end
    endtask

    initial begin
        test_reset();
`ifdef MIC_STEREO_EN
        test_stereo();
`else
        test_wake_and_ones();
        test_patterns();
        test_overrun();
        test_stop_restart();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
